// File: rtl/fp16_pkg.sv
// Shared binary16 format constants, flag layout and divider FSM types.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam int ITER  = MAN_W + 3;

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    localparam int FLG_INVALID   = 4;
    localparam int FLG_DIV_ZERO  = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  flg;
    } fp16_out_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 operand decode; exponent 0 is treated as zero (subnormals flushed).
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]      op_i,
    output logic             is_zero_o,
    output logic             is_inf_o,
    output logic             is_nan_o,
    output logic             sign_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [MAN_W:0]   man_o
);

    logic all_ones;

    assign sign_o    = op_i[15];
    assign exp_o     = op_i[MAN_W +: EXP_W];
    assign all_ones  = &exp_o;
    assign is_zero_o = (exp_o == '0);
    assign is_inf_o  = all_ones && (op_i[MAN_W-1:0] == '0);
    assign is_nan_o  = all_ones && (op_i[MAN_W-1:0] != '0);
    assign man_o     = {1'b1, op_i[MAN_W-1:0]};

endmodule

// File: rtl/fp16_divider_seq.sv
// Iterative binary16 divider: radix-2 restoring mantissa division, one op in flight, fixed latency.
module fp16_divider_seq
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [4:0]  flags
);

    localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [6:0]  exp_diff_q, exp_diff_d;
    logic [MAN_W:0]     mb_q, mb_d;
    logic [11:0]        rem_q, rem_d;
    logic [ITER-1:0]    quo_q, quo_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               spec_q, spec_d;
    fp16_out_t          spec_out_q, spec_out_d;
    logic [15:0]        result_q, result_d;
    logic [4:0]         flags_q, flags_d;

    logic               a_zero, a_inf, a_nan, a_sign;
    logic               b_zero, b_inf, b_nan, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W:0]     a_man, b_man;
    logic [11:0]        rem_sub;
    logic               q_bit;
    fp16_out_t          rnd_out;

    fp16_classify u_cls_a (
        .op_i(a), .is_zero_o(a_zero), .is_inf_o(a_inf), .is_nan_o(a_nan),
        .sign_o(a_sign), .exp_o(a_exp), .man_o(a_man)
    );

    fp16_classify u_cls_b (
        .op_i(b), .is_zero_o(b_zero), .is_inf_o(b_inf), .is_nan_o(b_nan),
        .sign_o(b_sign), .exp_o(b_exp), .man_o(b_man)
    );

    // Normalise the 13-bit quotient, round to nearest even, then range-check the exponent.
    function automatic fp16_out_t round_pack(input logic sgn, input logic signed [6:0] ediff,
                                             input logic [ITER-1:0] q, input logic rem_nz);
        logic [9:0]        m;
        logic              g, s;
        logic signed [7:0] e;
        logic [10:0]       mr;
        fp16_out_t         o;
        if (q[ITER-1]) begin
            m = q[11:2];
            g = q[1];
            s = q[0] | rem_nz;
            e = 8'(ediff) + 8'(BIAS);
        end else begin
            m = q[10:1];
            g = q[0];
            s = rem_nz;
            e = 8'(ediff) + 8'(BIAS) - 8'sd1;
        end
        mr = {1'b0, m} + {10'd0, g & (s | m[0])};
        if (mr[10]) e = e + 8'sd1;
        o.flg = '0;
        if (e >= 8'sd31) begin
            o.res = POS_INF | {sgn, 15'd0};
            o.flg[FLG_OVERFLOW] = 1'b1;
            o.flg[FLG_INEXACT]  = 1'b1;
        end else if (e <= 8'sd0) begin
            o.res = {sgn, 15'd0};
            o.flg[FLG_UNDERFLOW] = 1'b1;
            o.flg[FLG_INEXACT]   = 1'b1;
        end else begin
            o.res = {sgn, e[4:0], mr[9:0]};
            o.flg[FLG_INEXACT] = g | s;
        end
        return o;
    endfunction

    assign rem_sub = rem_q - {1'b0, mb_q};
    assign q_bit   = (rem_q >= {1'b0, mb_q});
    assign rnd_out = round_pack(sign_q, exp_diff_q, quo_q, rem_q != '0);

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_diff_d = exp_diff_q;
        mb_d       = mb_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_out_d = spec_out_q;
        result_d   = result_q;
        flags_d    = flags_q;
        in_ready   = (state_q == IDLE) && !rst;
        out_valid  = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d     = a_sign ^ b_sign;
                    exp_diff_d = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
                    rem_d      = {1'b0, a_man};
                    mb_d       = b_man;
                    quo_d      = '0;
                    cnt_d      = '0;
                    spec_d     = 1'b1;
                    spec_out_d = '0;
                    // Specials are decided now; the divide still runs so latency stays fixed.
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        spec_out_d.res = QNAN;
                        spec_out_d.flg[FLG_INVALID] = 1'b1;
                    end else if (a_inf) begin
                        spec_out_d.res = POS_INF | {a_sign ^ b_sign, 15'd0};
                    end else if (b_zero) begin
                        spec_out_d.res = POS_INF | {a_sign ^ b_sign, 15'd0};
                        spec_out_d.flg[FLG_DIV_ZERO] = 1'b1;
                    end else if (a_zero || b_inf) begin
                        spec_out_d.res = {a_sign ^ b_sign, 15'd0};
                    end else begin
                        spec_d = 1'b0;
                    end
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = q_bit ? {rem_sub[10:0], 1'b0} : {rem_q[10:0], 1'b0};
                quo_d = {quo_q[ITER-2:0], q_bit};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) state_d = ROUND;
            end
            ROUND: begin
                result_d = spec_q ? spec_out_q.res : rnd_out.res;
                flags_d  = spec_q ? spec_out_q.flg : rnd_out.flg;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_diff_q <= '0;
            mb_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_out_q <= '0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_diff_q <= exp_diff_d;
            mb_q       <= mb_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_out_q <= spec_out_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp16_divider_seq.sv
// Directed bench for fp16_divider_seq: normal quotients, rounding, specials, range limits, backpressure, abort.
module tb_fp16_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp16_divider_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op with out_ready high; cyc counts clock edges from the accept edge (inclusive)
    // to the edge after which out_valid is first seen. A timeout returns X operands.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] res, output logic [4:0] flg, output int cyc);
        int w;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        if (out_valid) begin res = result; flg = flags; end
        else begin res = 'x; flg = 'x; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
        n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", flags); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic;
        logic [15:0] r; logic [4:0] f; int c;
        run_op(16'h4000, 16'h3C00, r, f, c);
        n_checks++; if (c !== 15) begin n_fail++; $display("FAIL basic_latency: got %0d expected 15", c); end
        n_checks++; if (r !== 16'h4000) begin n_fail++; $display("FAIL basic_2div1_res: got %h expected 4000", r); end
        n_checks++; if (f !== 5'b00000) begin n_fail++; $display("FAIL basic_2div1_flags: got %b expected 00000", f); end
        run_op(16'hC400, 16'h4000, r, f, c);
        n_checks++; if (r !== 16'hC000) begin n_fail++; $display("FAIL basic_neg4div2_res: got %h expected c000", r); end
        n_checks++; if (f !== 5'b00000) begin n_fail++; $display("FAIL basic_neg4div2_flags: got %b expected 00000", f); end
    endtask

    task automatic test_inexact;
        logic [15:0] r; logic [4:0] f; int c;
        run_op(16'h3C00, 16'h4200, r, f, c);
        n_checks++; if (r !== 16'h3555) begin n_fail++; $display("FAIL third_res: got %h expected 3555", r); end
        n_checks++; if (f !== 5'b00001) begin n_fail++; $display("FAIL third_flags: got %b expected 00001", f); end
    endtask

    task automatic test_special;
        logic [15:0] r; logic [4:0] f; int c;
        run_op(16'h3C00, 16'h0000, r, f, c);
        n_checks++; if (r !== 16'h7C00) begin n_fail++; $display("FAIL divzero_res: got %h expected 7c00", r); end
        n_checks++; if (f !== 5'b01000) begin n_fail++; $display("FAIL divzero_flags: got %b expected 01000", f); end
        n_checks++; if (c !== 15) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 15", c); end
        run_op(16'h8000, 16'h0000, r, f, c);
        n_checks++; if (r !== 16'h7E00) begin n_fail++; $display("FAIL zerozero_res: got %h expected 7e00", r); end
        n_checks++; if (f !== 5'b10000) begin n_fail++; $display("FAIL zerozero_flags: got %b expected 10000", f); end
        run_op(16'h7C00, 16'h7C00, r, f, c);
        n_checks++; if (r !== 16'h7E00) begin n_fail++; $display("FAIL infinf_res: got %h expected 7e00", r); end
        n_checks++; if (f !== 5'b10000) begin n_fail++; $display("FAIL infinf_flags: got %b expected 10000", f); end
    endtask

    task automatic test_range;
        logic [15:0] r; logic [4:0] f; int c;
        run_op(16'h7BFF, 16'h3800, r, f, c);
        n_checks++; if (r !== 16'h7C00) begin n_fail++; $display("FAIL overflow_res: got %h expected 7c00", r); end
        n_checks++; if (f !== 5'b00101) begin n_fail++; $display("FAIL overflow_flags: got %b expected 00101", f); end
        run_op(16'h0400, 16'h4000, r, f, c);
        n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL underflow_res: got %h expected 0000", r); end
        n_checks++; if (f !== 5'b00011) begin n_fail++; $display("FAIL underflow_flags: got %b expected 00011", f); end
    endtask

    task automatic test_backpressure;
        logic [15:0] r; logic [4:0] f; int c; int w;
        @(negedge clk);
        a = 16'h4000; b = 16'h3C00; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        c = 1;
        while (!out_valid && c < 40) begin @(posedge clk); #1; c++; end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_rise: got %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin in_valid = 1'b1; a = 16'h3C00; b = 16'h0000; end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk); #1;
            n_checks++; if (result !== 16'h4000) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h expected 4000", i, result); end
            n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL bp_hold_flags[%0d]: got %b expected 00000", i, flags); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        run_op(16'h3C00, 16'h4200, r, f, c);
        n_checks++; if (r !== 16'h3555) begin n_fail++; $display("FAIL bp_next_res: got %h expected 3555", r); end
        n_checks++; if (f !== 5'b00001) begin n_fail++; $display("FAIL bp_next_flags: got %b expected 00001", f); end
    endtask

    task automatic test_reset_abort;
        logic [15:0] r; logic [4:0] f; int c; int w; int seen;
        @(negedge clk);
        a = 16'h7BFF; b = 16'h3800; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready_in_rst: got %b expected 0", in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready_after: got %b expected 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_output: got %0d out_valid cycles expected 0", seen); end
        run_op(16'h4000, 16'h3C00, r, f, c);
        n_checks++; if (r !== 16'h4000) begin n_fail++; $display("FAIL abort_next_res: got %h expected 4000", r); end
        n_checks++; if (f !== 5'b00000) begin n_fail++; $display("FAIL abort_next_flags: got %b expected 00000", f); end
        n_checks++; if (c !== 15) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 15", c); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inexact();
        test_special();
        test_range();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_divider_seq.md
Name: fp16_divider_seq

Overview:
Iterative IEEE-754 binary16 divider (a / b) with valid/ready handshakes on input and output. It is the inverse-operation companion to the fp16 multiplier in the DSP block's floating-point path, and shares the same format conventions: 5-bit exponent, 10-bit mantissa, bias 15, subnormals flushed to zero, 5-bit flag vector. It uses radix-2 restoring mantissa division over a fixed number of cycles, one operation in flight.

Parameters:
EXP_W, 5, exponent width
MAN_W, 10, stored mantissa width (hidden bit added internally)
BIAS, 15, exponent bias
ITER, MAN_W+3 (13), quotient bits generated, one per cycle

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset: synchronous, active-high
in_valid  in  1  operands a/b valid
in_ready  out  1  block can accept; high only in IDLE and rst low
a  in  16  dividend, binary16
b  in  16  divisor, binary16
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  16  quotient, binary16
flags  out  5  [4] invalid, [3] div_by_zero, [2] overflow, [1] underflow, [0] inexact

Behaviour:
- Reset: state IDLE, out_valid=0, result=0, flags=0, remainder/quotient/counter=0. in_ready=0 while rst is high. rst mid-operation aborts and discards the operation; no output is produced.
- FSM: IDLE -> DIVIDE -> ROUND -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register sign=Sa^Sb, exp_diff=Ea-Eb (7-bit signed), Ma={1,a[9:0]}, Mb={1,b[9:0]}, and special-case class. Go to DIVIDE with cnt=0.
- DIVIDE, one quotient bit per cycle, ITER cycles, q MSB first:
  - rem starts at Ma (12 bits).
  - Each cycle: if rem>=Mb then q_bit=1 and rem-=Mb, else q_bit=0; then rem<<=1.
  - Leave for ROUND after cnt==ITER-1.
- ROUND:
  - If q[12]=1: M=q[11:2], G=q[1], S=q[0]|(rem!=0), E=exp_diff+BIAS.
  - Else: M=q[10:1], G=q[0], S=(rem!=0), E=exp_diff+BIAS-1.
  - Round to nearest even: increment M when G&(S|M[0]). If M carries out, M=0 and E+=1.
  - E>=31: result=Inf with sign, flags overflow|inexact.
  - E<=0: result=signed zero, flags underflow|inexact.
  - Otherwise inexact=G|S.
- Special cases are resolved at accept and override ROUND output. Latency is unchanged (constant latency); the DIVIDE result is ignored.
  - Exponent 0 is treated as zero (subnormal flushed).
  - NaN operand, 0/0, or Inf/Inf: result 16'h7E00, invalid.
  - Finite nonzero / 0: signed Inf (0x7C00 | sign<<15), div_by_zero.
  - Inf / finite: signed Inf, no flags.
  - 0 / nonzero, or finite / Inf: signed zero, no flags.
- DONE: out_valid=1. result and flags stay stable while out_ready=0. On out_ready, go to IDLE; out_valid drops on the next cycle.
- Latency: out_valid rises 15 cycles after the accepting edge (1 capture + 13 DIVIDE + 1 ROUND). Throughput: at most one op per 16 cycles.
- in_valid is ignored outside IDLE. in_ready and out_valid are never both high.
- No accept occurs in the same cycle as the DONE->IDLE transition.

Decomposition:
- Shared package fp16_pkg:
  - Constants: EXP_W, MAN_W, BIAS, QNAN=16'h7E00, POS_INF=16'h7C00.
  - Flag bit index constants FLG_INVALID..FLG_INEXACT.
  - FSM state typedef {IDLE, DIVIDE, ROUND, DONE}.
- Sub-module fp16_classify (combinational, instantiated twice): input 16-bit operand; outputs is_zero, is_inf, is_nan, sign, exp, man_with_hidden.

Test Plan:
1. a=0x4000 (2.0), b=0x3C00 (1.0) -> result 0x4000, flags 0. out_valid exactly 15 cycles after accept. Also a=0xC400, b=0x4000 -> 0xC000.
2. a=0x3C00, b=0x4200 (1/3) -> result 0x3555, flags 5'b00001 (inexact).
3. a=0x3C00, b=0x0000 -> 0x7C00, flags 5'b01000. a=0x8000, b=0x0000 -> 0x7E00, flags 5'b10000. a=0x7C00, b=0x7C00 -> 0x7E00, invalid.
4. a=0x7BFF, b=0x3800 -> 0x7C00, flags 5'b00101. a=0x0400, b=0x4000 -> 0x0000, flags 5'b00011.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
   - result/flags must stay stable and in_ready=0; a pulsed in_valid is ignored.
   - On out_ready=1, out_valid drops next cycle, in_ready rises, and the following op completes correctly.
6. Assert rst for 1 cycle during DIVIDE iteration 6.
   - out_valid stays 0, and no result is emitted for the aborted op.
   - in_ready=1 the cycle after rst falls; the next op (0x4000/0x3C00) returns 0x4000.
